// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//   UART serialiser with a valid/ready input handshake, single clock domain.
//   Bit timing comes from an internal baud counter used as a clock enable,
//   not from a derived clock. Frame: start bit, DATA_BITS data bits sent LSB
//   first, optional parity bit, STOP_BITS stop bits.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> a parity bit follows the data; PARITY_ODD selects odd
//                  (1) or even (0) parity.
//     undefined -> no PARITY state and no parity logic; PARITY_ODD unused.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   DATA_BITS     data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1..2)
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   tx_data   in   word to send, captured only on accept
//   tx_valid  in   upstream has a word
//   tx_ready  out  high only while idle; accept = tx_valid && tx_ready
//   tx        out  registered serial line, idles high
//   busy      out  frame in progress
//   done      out  single-cycle pulse in the last cycle of the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    // Elaboration-time parameter checks.
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1..2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int STP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state, next_state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic [STP_W-1:0]     stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tx_next;

    logic bit_end, last_data, last_stop, accept;

    assign bit_end   = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign last_data = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = (stop_cnt == STP_W'(STOP_BITS - 1));
    assign accept    = tx_valid && (state == S_IDLE);

    // Data-bit index for the coming cycle; tx is registered, so the line
    // value is computed from next-cycle state and index.
    assign bit_idx_next = (state != S_DATA) ? '0 :
                          (bit_end ? bit_idx + 1'b1 : bit_idx);

    // ---------------- state register ----------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples values from before the edge, whatever the block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // ---------------- next-state logic ----------------
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (tx_valid) next_state = S_START;
            S_START: if (bit_end)  next_state = S_DATA;
            S_DATA:
                if (bit_end && last_data) begin
`ifdef UART_TX_PARITY_EN
                    next_state = S_PARITY;
`else
                    next_state = S_STOP;
`endif
                end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) next_state = S_STOP;
`endif
            S_STOP:  if (bit_end && last_stop) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        tx_ready = (state == S_IDLE);
        busy     = (state != S_IDLE);
        done     = (state == S_STOP) && bit_end && last_stop;
        tx_next  = 1'b1;
        case (next_state)
            S_START:  tx_next = 1'b0;
            // On accept the shift register is loaded this edge, so the
            // first data bit is only needed once START has ended.
            S_DATA:   tx_next = shift[bit_idx_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next = (^shift) ^ (PARITY_ODD != 0);
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= '0;
            shift    <= '0;
        end else begin
            tx <= tx_next;

            // Counter idles at zero, so accept starts the start bit fresh.
            if (state == S_IDLE || bit_end) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + 1'b1;

            if (accept) shift <= tx_data;

            bit_idx <= (next_state == S_DATA) ? bit_idx_next : '0;

            if (state != next_state)          stop_cnt <= '0;
            else if (state == S_STOP && bit_end) stop_cnt <= stop_cnt + 1'b1;
        end
    end

endmodule
